traffic_light_controller: RTL and testbench

Parametrised two-direction (row/column) intersection controller with configurable phase durations, an all-red clearance interval, a flashing-yellow night mode and two-digit BCD countdown outputs per direction. It replaces the fixed 64-step countdown/decoder controller. The BCD outputs feed the existing seven-segment display drivers, and the light outputs drive the lamp pins directly.

---
 rtl/traffic_pkg.sv | 31 +++
 rtl/binary_to_bcd.sv | 23 ++
 rtl/tick_generator.sv | 27 ++
 rtl/traffic_light_controller.sv | 144 ++++++++++++++
 tb/tb_traffic_light_controller.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state encoding and lamp constants for the intersection controller
package traffic_pkg;

   typedef enum logic [2:0] {
      ROW_GREEN  = 3'd0,
      ROW_YELLOW = 3'd1,
      ALL_RED_C  = 3'd2,
      COL_GREEN  = 3'd3,
      COL_YELLOW = 3'd4,
      ALL_RED_R  = 3'd5,
      FLASH      = 3'd6
   } tl_state_e;

   localparam logic [2:0] LIGHT_RED    = 3'b100;
   localparam logic [2:0] LIGHT_YELLOW = 3'b010;
   localparam logic [2:0] LIGHT_GREEN  = 3'b001;
   localparam logic [2:0] LIGHT_OFF    = 3'b000;

   // Successor in the normal day cycle; FLASH and unused codes restart at ROW_GREEN.
   function automatic tl_state_e next_normal(input tl_state_e s);
      case (s)
         ROW_GREEN:  return ROW_YELLOW;
         ROW_YELLOW: return ALL_RED_C;
         ALL_RED_C:  return COL_GREEN;
         COL_GREEN:  return COL_YELLOW;
         COL_YELLOW: return ALL_RED_R;
         default:    return ROW_GREEN;
      endcase
   endfunction

endpackage

// File: rtl/binary_to_bcd.sv
// rtl/binary_to_bcd.sv - two-digit BCD conversion of a 7-bit value in the range 0..99
module binary_to_bcd (
   input  logic [6:0] binary,
   output logic [7:0] bcd
);

   logic [6:0] rest;
   logic [3:0] tens;

   // Nine conditional subtractions are enough to strip every ten from 0..99.
   always_comb begin
      rest = binary;
      tens = 4'd0;
      for (int i = 0; i < 9; i++) begin
         if (rest >= 7'd10) begin
            rest = rest - 7'd10;
            tens = tens + 4'd1;
         end
      end
      bcd = {tens, rest[3:0]};
   end

endmodule

// File: rtl/tick_generator.sv
// rtl/tick_generator.sv - free-running divider producing a one-cycle tick every CLK_PER_SEC cycles
module tick_generator #(
   parameter int CLK_PER_SEC = 50_000_000
) (
   input  logic clock,
   input  logic reset,
   output logic tick
);

   localparam int CNT_W = $clog2(CLK_PER_SEC);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_SEC - 1);

   logic [CNT_W-1:0] count;

   assign tick = (count == LAST);

   always_ff @(posedge clock) begin
      if (!reset) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/traffic_light_controller.sv
// rtl/traffic_light_controller.sv - row/column intersection controller with all-red clearance, night flash and BCD countdowns
module traffic_light_controller
   import traffic_pkg::*;
#(
   parameter int CLK_PER_SEC = 50_000_000,
   parameter int GREEN_SEC   = 25,
   parameter int YELLOW_SEC  = 3,
   parameter int ALL_RED_SEC = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       night_mode,
   output logic [2:0] row_traffic_lights,
   output logic [2:0] column_traffic_lights,
   output logic [7:0] row_bcd,
   output logic [7:0] column_bcd
);

   if (CLK_PER_SEC < 2 || GREEN_SEC < 1 || YELLOW_SEC < 1 || ALL_RED_SEC < 1 ||
       GREEN_SEC + YELLOW_SEC + 2 * ALL_RED_SEC > 99) begin : g_bad_params
      $error("traffic_light_controller: illegal timing parameters");
   end

   localparam logic [6:0] G_SEC = 7'(GREEN_SEC);
   localparam logic [6:0] Y_SEC = 7'(YELLOW_SEC);
   localparam logic [6:0] A_SEC = 7'(ALL_RED_SEC);

   function automatic logic [6:0] duration(input tl_state_e s);
      case (s)
         ROW_GREEN, COL_GREEN:   return G_SEC;
         ROW_YELLOW, COL_YELLOW: return Y_SEC;
         default:                return A_SEC;
      endcase
   endfunction

   logic       tick;
   tl_state_e  state_q, state_d;
   logic [6:0] rem_q, rem_d;
   logic       flash_q, flash_d;
   logic [6:0] row_disp, col_disp;

   tick_generator #(
      .CLK_PER_SEC(CLK_PER_SEC)
   ) u_tick (
      .clock(clock),
      .reset(reset),
      .tick (tick)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ROW_GREEN;
         rem_q   <= G_SEC;
         flash_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         flash_q <= flash_d;
      end
   end

   always_comb begin
      state_d               = state_q;
      rem_d                 = rem_q;
      flash_d               = flash_q;
      row_traffic_lights    = LIGHT_RED;
      column_traffic_lights = LIGHT_RED;
      row_disp              = 7'd0;
      col_disp              = 7'd0;

      // Night requests are only honoured on tick cycles and take priority over phase expiry.
      if (tick) begin
         if (state_q == FLASH) begin
            if (night_mode) begin
               flash_d = ~flash_q;
            end else begin
               state_d = ALL_RED_R;
               rem_d   = A_SEC;
               flash_d = 1'b0;
            end
         end else if (night_mode) begin
            state_d = FLASH;
            flash_d = 1'b1;
         end else if (rem_q == 7'd1) begin
            state_d = next_normal(state_q);
            rem_d   = duration(next_normal(state_q));
         end else begin
            rem_d = rem_q - 7'd1;
         end
      end

      // A red direction counts down to its next green; an active direction counts down to its red.
      case (state_q)
         ROW_GREEN: begin
            row_traffic_lights = LIGHT_GREEN;
            row_disp           = rem_q + Y_SEC;
            col_disp           = rem_q + Y_SEC + A_SEC;
         end
         ROW_YELLOW: begin
            row_traffic_lights = LIGHT_YELLOW;
            row_disp           = rem_q;
            col_disp           = rem_q + A_SEC;
         end
         ALL_RED_C: begin
            col_disp = rem_q;
            row_disp = rem_q + G_SEC + Y_SEC + A_SEC;
         end
         COL_GREEN: begin
            column_traffic_lights = LIGHT_GREEN;
            col_disp              = rem_q + Y_SEC;
            row_disp              = rem_q + Y_SEC + A_SEC;
         end
         COL_YELLOW: begin
            column_traffic_lights = LIGHT_YELLOW;
            col_disp              = rem_q;
            row_disp              = rem_q + A_SEC;
         end
         ALL_RED_R: begin
            row_disp = rem_q;
            col_disp = rem_q + G_SEC + Y_SEC + A_SEC;
         end
         FLASH: begin
            row_traffic_lights    = flash_q ? LIGHT_YELLOW : LIGHT_OFF;
            column_traffic_lights = flash_q ? LIGHT_YELLOW : LIGHT_OFF;
         end
         default: begin
            state_d = ROW_GREEN;
            rem_d   = G_SEC;
            flash_d = 1'b0;
         end
      endcase
   end

   binary_to_bcd u_row_bcd (
      .binary(row_disp),
      .bcd   (row_bcd)
   );

   binary_to_bcd u_col_bcd (
      .binary(col_disp),
      .bcd   (column_bcd)
   );

endmodule

// File: tb/tb_traffic_light_controller.sv
// tb/tb_traffic_light_controller.sv - directed and randomized checks of traffic_light_controller against a timeline model
module tb_traffic_light_controller;

   localparam int CPS   = 4;
   localparam int G     = 5;
   localparam int Y     = 2;
   localparam int A     = 1;
   localparam int HALF  = G + Y + A;
   localparam int CYCLE = 2 * HALF;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       night_mode = 1'b0;
   logic [2:0] row_traffic_lights;
   logic [2:0] column_traffic_lights;
   logic [7:0] row_bcd;
   logic [7:0] column_bcd;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model: position in seconds within the full cycle, plus night-flash flags.
   int m_div   = 0;
   int m_pos   = 0;
   bit m_flash = 1'b0;
   bit m_ph    = 1'b0;

   traffic_light_controller #(
      .CLK_PER_SEC(CPS),
      .GREEN_SEC  (G),
      .YELLOW_SEC (Y),
      .ALL_RED_SEC(A)
   ) dut (
      .clock                (clock),
      .reset                (reset),
      .night_mode           (night_mode),
      .row_traffic_lights   (row_traffic_lights),
      .column_traffic_lights(column_traffic_lights),
      .row_bcd              (row_bcd),
      .column_bcd           (column_bcd)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] t;
      logic [3:0] u;
      t = 4'(v / 10);
      u = 4'(v % 10);
      return {t, u};
   endfunction

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_update(input logic rst, input logic night);
      bit tick;
      if (!rst) begin
         m_div = 0; m_pos = 0; m_flash = 1'b0; m_ph = 1'b0;
      end else begin
         tick  = (m_div == CPS - 1);
         m_div = (m_div + 1) % CPS;
         if (tick) begin
            if (m_flash) begin
               if (night) m_ph = !m_ph;
               else begin
                  m_flash = 1'b0;
                  m_pos   = CYCLE - A;
               end
            end else if (night) begin
               m_flash = 1'b1;
               m_ph    = 1'b1;
            end else begin
               m_pos = (m_pos + 1) % CYCLE;
            end
         end
      end
   endtask

   task automatic check_model();
      logic [2:0] er, ec;
      int rv, cv;
      if (m_flash) begin
         er = m_ph ? 3'b010 : 3'b000;
         ec = er;
         rv = 0;
         cv = 0;
      end else begin
         er = (m_pos < G) ? 3'b001 : (m_pos < G + Y) ? 3'b010 : 3'b100;
         ec = (m_pos >= HALF && m_pos < HALF + G)     ? 3'b001 :
              (m_pos >= HALF + G && m_pos < HALF + G + Y) ? 3'b010 : 3'b100;
         rv = (m_pos < G + Y) ? (G + Y - m_pos) : (CYCLE - m_pos);
         cv = (m_pos < HALF) ? (HALF - m_pos) :
              (m_pos < HALF + G + Y) ? (HALF + G + Y - m_pos) : (CYCLE + HALF - m_pos);
         checks++;
         assert (row_traffic_lights == 3'b100 || column_traffic_lights == 3'b100) else begin
            errors++;
            $error("FAIL safety cyc=%0d observed=%b/%b expected=one red", cyc,
                   row_traffic_lights, column_traffic_lights);
         end
      end
      chk8("model_row_lights", {5'd0, row_traffic_lights}, {5'd0, er});
      chk8("model_col_lights", {5'd0, column_traffic_lights}, {5'd0, ec});
      chk8("model_row_bcd", row_bcd, to_bcd(rv));
      chk8("model_col_bcd", column_bcd, to_bcd(cv));
   endtask

   task automatic step(input logic rst, input logic night);
      reset      = rst;
      night_mode = night;
      model_update(rst, night);
      @(posedge clock);
      #1;
      if (!rst) cyc = 0;
      else cyc++;
      check_model();
   endtask

   task automatic run_to(input int n, input logic night);
      while (cyc < n) step(1'b1, night);
   endtask

   task automatic expect_out(input string tag, input logic [2:0] rl, input logic [2:0] cl,
                             input logic [7:0] rb, input logic [7:0] cb);
      chk8({tag, "_row_l"}, {5'd0, row_traffic_lights}, {5'd0, rl});
      chk8({tag, "_col_l"}, {5'd0, column_traffic_lights}, {5'd0, cl});
      chk8({tag, "_row_bcd"}, row_bcd, rb);
      chk8({tag, "_col_bcd"}, column_bcd, cb);
   endtask

   initial begin
      // Normal sequence after reset
      step(1'b0, 1'b0);
      expect_out("reset", 3'b001, 3'b100, 8'h07, 8'h08);
      run_to(4, 1'b0);
      expect_out("c4", 3'b001, 3'b100, 8'h06, 8'h07);
      run_to(20, 1'b0);
      expect_out("c20", 3'b010, 3'b100, 8'h02, 8'h03);
      run_to(28, 1'b0);
      expect_out("c28", 3'b100, 3'b100, 8'h09, 8'h01);
      run_to(32, 1'b0);
      expect_out("c32", 3'b100, 3'b001, 8'h08, 8'h07);
      run_to(64, 1'b0);
      expect_out("c64", 3'b001, 3'b100, 8'h07, 8'h08);
      run_to(256, 1'b0);

      // Night mode held from cycle 10, dropped after the cycle-19 tick
      step(1'b0, 1'b0);
      run_to(10, 1'b0);
      run_to(12, 1'b1);
      expect_out("flash12", 3'b010, 3'b010, 8'h00, 8'h00);
      run_to(16, 1'b1);
      expect_out("flash16", 3'b000, 3'b000, 8'h00, 8'h00);
      run_to(20, 1'b1);
      expect_out("flash20", 3'b010, 3'b010, 8'h00, 8'h00);
      run_to(24, 1'b0);
      expect_out("exit24", 3'b100, 3'b100, 8'h01, 8'h09);
      run_to(28, 1'b0);
      expect_out("exit28", 3'b001, 3'b100, 8'h07, 8'h08);

      // Night pulse that misses every tick
      step(1'b0, 1'b0);
      run_to(13, 1'b0);
      run_to(15, 1'b1);
      run_to(16, 1'b0);
      expect_out("pulse16", 3'b001, 3'b100, 8'h03, 8'h04);

      // Reset during ALL_RED_C restarts the timeline
      run_to(30, 1'b0);
      step(1'b0, 1'b0);
      expect_out("rst_mid", 3'b001, 3'b100, 8'h07, 8'h08);
      run_to(4, 1'b0);
      expect_out("rst_c4", 3'b001, 3'b100, 8'h06, 8'h07);
      run_to(20, 1'b0);
      expect_out("rst_c20", 3'b010, 3'b100, 8'h02, 8'h03);

      // Randomized night requests and occasional resets
      begin
         logic night;
         night = 1'b0;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 24) == 0) night = ~night;
            step(($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1, night);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
